// File: rtl/adc_afe_pkg.sv
// Shared definitions for the ADC analog front-end host sequencer and controller.
// Gain width and channel count live here so both sides agree on one definition.
package adc_afe_pkg;

  localparam int          GAIN_W            = 2;
  localparam int          NUM_CHAN          = 2;
  localparam logic [15:0] SETTLE_CYCLES_DEF = 16'd200;

  localparam logic CMD_GAIN = 1'b0;
  localparam logic CMD_PWR  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESP   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that stops at zero; done is high whenever the count is zero.
module settle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] count_r;

  // Load has priority; decrement saturates at zero so the count never wraps.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/adc_afe_host_seq.sv
// Host-side sequencer: applies one gain/power-down request, waits the settle time,
// then returns the controller's termination state as a response.
module adc_afe_host_seq
  import adc_afe_pkg::*;
#(
  parameter int               CNT_W         = 16,
  parameter logic [CNT_W-1:0] SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic              cmd_type_in,
  input  logic              cmd_chan_in,
  input  logic [GAIN_W-1:0] cmd_data_in,
  output logic [GAIN_W-1:0] gain0_out,
  output logic [GAIN_W-1:0] gain1_out,
  output logic [NUM_CHAN-1:0] power_down_out,
  input  logic [1:0]        term_state_in,
  output logic              resp_valid_out,
  input  logic              resp_ready_in,
  output logic [1:0]        resp_term_out,
  output logic              resp_chan_out,
  output logic              busy_out
);

  localparam logic [CNT_W-1:0] LOAD_VALUE = SETTLE_CYCLES - {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_e          state_r;
  logic                cmd_type_r;
  logic                cmd_chan_r;
  logic [GAIN_W-1:0]   cmd_data_r;
  logic                cmd_ready_r;
  logic                busy_r;
  logic [GAIN_W-1:0]   gain0_r;
  logic [GAIN_W-1:0]   gain1_r;
  logic [NUM_CHAN-1:0] power_down_r;
  logic                resp_valid_r;
  logic [1:0]          resp_term_r;
  logic                resp_chan_r;
  logic                timer_load_s;
  logic                timer_en_s;
  logic                timer_done_s;

  assign timer_load_s = (state_r == ST_APPLY);
  assign timer_en_s   = (state_r == ST_SETTLE);

  settle_timer #(.CNT_W(CNT_W)) u_settle_timer (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .load       (timer_load_s),
    .enable     (timer_en_s),
    .load_value (LOAD_VALUE),
    .done       (timer_done_s)
  );

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r      <= ST_IDLE;
      cmd_type_r   <= 1'b0;
      cmd_chan_r   <= 1'b0;
      cmd_data_r   <= {GAIN_W{1'b0}};
      cmd_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      gain0_r      <= {GAIN_W{1'b0}};
      gain1_r      <= {GAIN_W{1'b0}};
      power_down_r <= {NUM_CHAN{1'b0}};
      resp_valid_r <= 1'b0;
      resp_term_r  <= 2'b00;
      resp_chan_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid_in && cmd_ready_r) begin
            cmd_type_r  <= cmd_type_in;
            cmd_chan_r  <= cmd_chan_in;
            cmd_data_r  <= cmd_data_in;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_APPLY;
          end else begin
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (cmd_type_r == CMD_GAIN) begin
            if (cmd_chan_r == 1'b0) begin
              gain0_r <= cmd_data_r;
            end else begin
              gain1_r <= cmd_data_r;
            end
          end else begin
            power_down_r[cmd_chan_r] <= cmd_data_r[0];
          end
          state_r <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_done_s) begin
            state_r <= ST_SAMPLE;
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        ST_SAMPLE: begin
          resp_term_r  <= term_state_in;
          resp_chan_r  <= cmd_chan_r;
          resp_valid_r <= 1'b1;
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready_in) begin
            resp_valid_r <= 1'b0;
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        // Corrupted encoding: recover to IDLE, request outputs untouched.
        default: begin
          resp_valid_r <= 1'b0;
          cmd_ready_r  <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_out  = cmd_ready_r;
  assign busy_out       = busy_r;
  assign gain0_out      = gain0_r;
  assign gain1_out      = gain1_r;
  assign power_down_out = power_down_r;
  assign resp_valid_out = resp_valid_r;
  assign resp_term_out  = resp_term_r;
  assign resp_chan_out  = resp_chan_r;

endmodule

// File: tb/tb_adc_afe_host_seq.sv
// Self-checking bench for adc_afe_host_seq: command table plus hand sequences,
// responses compared against a scoreboard filled at command acceptance.
module tb_adc_afe_host_seq;

  localparam logic [15:0] SETTLE = 16'd10;
  localparam int          LAT    = 12;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       cmd_valid_in;
  logic       cmd_ready_out;
  logic       cmd_type_in;
  logic       cmd_chan_in;
  logic [1:0] cmd_data_in;
  logic [1:0] gain0_out;
  logic [1:0] gain1_out;
  logic [1:0] power_down_out;
  logic [1:0] term_state_in;
  logic       resp_valid_out;
  logic       resp_ready_in;
  logic [1:0] resp_term_out;
  logic       resp_chan_out;
  logic       busy_out;

  adc_afe_host_seq #(.CNT_W(16), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cmd_valid_in   (cmd_valid_in),
    .cmd_ready_out  (cmd_ready_out),
    .cmd_type_in    (cmd_type_in),
    .cmd_chan_in    (cmd_chan_in),
    .cmd_data_in    (cmd_data_in),
    .gain0_out      (gain0_out),
    .gain1_out      (gain1_out),
    .power_down_out (power_down_out),
    .term_state_in  (term_state_in),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready_in),
    .resp_term_out  (resp_term_out),
    .resp_chan_out  (resp_chan_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       typ;
    logic       chan;
    logic [1:0] data;
    logic [1:0] term;
    logic [1:0] g0;
    logic [1:0] g1;
    logic [1:0] pd;
  } vec_t;

  typedef struct {
    logic [1:0] term;
    logic       chan;
  } resp_t;

  vec_t  vecs[6];
  resp_t sb_q[$];
  int    vec_cnt  = 0;
  int    miss_cnt = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Present a command and wait for its acceptance edge; returns at the following negedge.
  task automatic issue(input logic typ, input logic chan, input logic [1:0] data,
                       input logic [1:0] term, input bit keep_valid);
    bit    ok;
    resp_t r;
    ok            = 1'b0;
    cmd_type_in   = typ;
    cmd_chan_in   = chan;
    cmd_data_in   = data;
    term_state_in = term;
    cmd_valid_in  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready_out) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    chk1("accept_wait", ok, 1'b1);
    @(posedge clk_in);
    r.term = term;
    r.chan = chan;
    sb_q.push_back(r);
    @(negedge clk_in);
    if (!keep_valid) cmd_valid_in = 1'b0;
  endtask

  // Follow a command through to its response handshake.
  task automatic complete(input logic [1:0] g0, input logic [1:0] g1, input logic [1:0] pd,
                          input int bp);
    resp_t exp;
    int    lat;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (k == 1) begin
        chk2("gain0", gain0_out, g0);
        chk2("gain1", gain1_out, g1);
        chk2("power_down", power_down_out, pd);
        chk1("busy", busy_out, 1'b1);
      end
      if (resp_valid_out) begin
        lat = k;
        break;
      end
      chk1("ready_while_busy", cmd_ready_out, 1'b0);
    end
    vec_cnt++;
    if (lat != LAT) begin
      miss_cnt++;
      $display("FAIL latency: got %0d expected %0d", lat, LAT);
    end
    if (sb_q.size() == 0) begin
      exp.term = 2'bxx;
      exp.chan = 1'bx;
    end else begin
      exp = sb_q.pop_front();
    end
    for (int c = 0; c < bp; c++) begin
      term_state_in = ~term_state_in;
      @(posedge clk_in);
      @(negedge clk_in);
      chk1("bp_valid", resp_valid_out, 1'b1);
      chk2("bp_term", resp_term_out, exp.term);
      chk1("bp_ready", cmd_ready_out, 1'b0);
    end
    chk2("resp_term", resp_term_out, exp.term);
    chk1("resp_chan", resp_chan_out, exp.chan);
    resp_ready_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    resp_ready_in = 1'b0;
    chk1("valid_after_hs", resp_valid_out, 1'b0);
    chk1("ready_after_hs", cmd_ready_out, 1'b1);
    chk1("busy_after_hs", busy_out, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    vecs[0] = '{typ: 1'b0, chan: 1'b1, data: 2'b01, term: 2'b10, g0: 2'b00, g1: 2'b01, pd: 2'b00};
    vecs[1] = '{typ: 1'b1, chan: 1'b0, data: 2'b01, term: 2'b01, g0: 2'b00, g1: 2'b01, pd: 2'b01};
    vecs[2] = '{typ: 1'b1, chan: 1'b1, data: 2'b01, term: 2'b11, g0: 2'b00, g1: 2'b01, pd: 2'b11};
    vecs[3] = '{typ: 1'b0, chan: 1'b0, data: 2'b11, term: 2'b00, g0: 2'b11, g1: 2'b01, pd: 2'b11};
    vecs[4] = '{typ: 1'b0, chan: 1'b0, data: 2'b11, term: 2'b01, g0: 2'b11, g1: 2'b01, pd: 2'b11};
    vecs[5] = '{typ: 1'b1, chan: 1'b0, data: 2'b10, term: 2'b10, g0: 2'b11, g1: 2'b01, pd: 2'b10};

    rst_in        = 1'b1;
    cmd_valid_in  = 1'b0;
    cmd_type_in   = 1'b0;
    cmd_chan_in   = 1'b0;
    cmd_data_in   = 2'b00;
    term_state_in = 2'b00;
    resp_ready_in = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk2("rst_gain0", gain0_out, 2'b00);
    chk2("rst_gain1", gain1_out, 2'b00);
    chk2("rst_pd", power_down_out, 2'b00);
    chk1("rst_valid", resp_valid_out, 1'b0);
    chk2("rst_term", resp_term_out, 2'b00);
    chk1("rst_chan", resp_chan_out, 1'b0);
    chk1("rst_busy", busy_out, 1'b0);
    chk1("rst_ready", cmd_ready_out, 1'b0);
    rst_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    chk1("ready_after_rst", cmd_ready_out, 1'b1);
    chk1("idle_busy", busy_out, 1'b0);

    // Command table, including a repeat of an unchanged gain value
    for (int v = 0; v < 6; v++) begin
      issue(vecs[v].typ, vecs[v].chan, vecs[v].data, vecs[v].term, 1'b0);
      complete(vecs[v].g0, vecs[v].g1, vecs[v].pd, 0);
    end

    // Backpressure with toggling term state
    issue(1'b0, 1'b1, 2'b10, 2'b01, 1'b0);
    complete(2'b11, 2'b10, 2'b10, 20);

    // Command valid held while busy: next accept one cycle after the handshake
    issue(1'b1, 1'b0, 2'b01, 2'b00, 1'b1);
    cmd_type_in = 1'b0;
    cmd_chan_in = 1'b0;
    cmd_data_in = 2'b00;
    complete(2'b11, 2'b10, 2'b11, 0);
    term_state_in = 2'b10;
    @(posedge clk_in);
    sb_q.push_back('{term: 2'b10, chan: 1'b0});
    @(negedge clk_in);
    cmd_valid_in = 1'b0;
    chk1("held_accept_busy", busy_out, 1'b1);
    chk1("held_accept_ready", cmd_ready_out, 1'b0);
    complete(2'b00, 2'b10, 2'b11, 0);

    // Reset while the settle counter reads 5
    issue(1'b0, 1'b0, 2'b01, 2'b11, 1'b0);
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    chk2("midrst_gain0", gain0_out, 2'b00);
    chk2("midrst_gain1", gain1_out, 2'b00);
    chk2("midrst_pd", power_down_out, 2'b00);
    chk1("midrst_valid", resp_valid_out, 1'b0);
    chk1("midrst_busy", busy_out, 1'b0);
    chk1("midrst_ready", cmd_ready_out, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (resp_valid_out) seen = 1'b1;
    end
    chk1("midrst_no_resp", seen, 1'b0);
    chk1("midrst_ready_back", cmd_ready_out, 1'b1);
    issue(1'b1, 1'b1, 2'b01, 2'b10, 1'b0);
    complete(2'b00, 2'b00, 2'b10, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
